// File: rtl/hazard_scoreboard.sv
// Register-mask hazard scoreboard: holds decode on RAW/WAW conflicts with in-flight stages.
// Optional macro HAZARD_SCOREBOARD_BYPASS_EN forwards from the last stage, removing it from the RAW check.
module hazard_scoreboard #(
    parameter int NREGS       = 16,
    parameter int DEPTH       = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [NREGS-1:0]       id_req,
    input  logic [NREGS-1:0]       id_prov,
    input  logic                   flush,
    input  logic                   stat_clr,
    output logic                   stall,
    output logic                   accept,
    output logic [NREGS-1:0]       busy_mask,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [NREGS-1:0]       bypass_hit,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [DEPTH-1:0] valid_q;
    logic [NREGS-1:0] prov_q [DEPTH];
    logic             raw_hit;
    logic             waw_hit;

    // Only provided registers matter for hazards; a stage's read set never blocks anyone.
    always_comb begin
        raw_hit   = 1'b0;
        waw_hit   = 1'b0;
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                busy_mask = busy_mask | prov_q[i];
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
                if ((i != DEPTH - 1) && ((id_req & prov_q[i]) != '0))
                    raw_hit = 1'b1;
`else
                if ((id_req & prov_q[i]) != '0)
                    raw_hit = 1'b1;
`endif
                if ((id_prov & prov_q[i]) != '0)
                    waw_hit = 1'b1;
            end
        end
    end

    assign stall       = id_valid & (raw_hit | waw_hit);
    assign accept      = id_valid & ~stall & ~flush;
    assign stage_valid = valid_q;

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
    assign bypass_hit = (id_valid && valid_q[DEPTH-1]) ? (id_req & prov_q[DEPTH-1]) : '0;
`else
    assign bypass_hit = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                prov_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                prov_q[i] <= '0;
        end else begin
            valid_q[0] <= accept;
            prov_q[0]  <= accept ? id_prov : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                prov_q[i]  <= prov_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (stat_clr)
            stall_cnt <= '0;
        else if (stall && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against an age-queue reference model.
module tb_hazard_scoreboard;

    localparam int NREGS = 16;
    localparam int DEPTH = 3;
    localparam int SCW   = 4;
    localparam int CMAX  = (1 << SCW) - 1;
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             id_valid = 1'b0;
    logic [NREGS-1:0] id_req = '0;
    logic [NREGS-1:0] id_prov = '0;
    logic             flush = 1'b0;
    logic             stat_clr = 1'b0;
    logic             stall;
    logic             accept;
    logic [NREGS-1:0] busy_mask;
    logic [DEPTH-1:0] stage_valid;
    logic [NREGS-1:0] bypass_hit;
    logic [SCW-1:0]   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state: each in-flight instruction with its provided set and age in cycles
    logic [NREGS-1:0] m_prov [$];
    int               m_age  [$];
    int               m_cnt  = 0;

    logic             s_stall, s_accept;
    logic [NREGS-1:0] s_byp;
    logic [SCW-1:0]   s_cnt;

    hazard_scoreboard #(.NREGS(NREGS), .DEPTH(DEPTH), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_req(id_req), .id_prov(id_prov),
        .flush(flush), .stat_clr(stat_clr), .stall(stall), .accept(accept),
        .busy_mask(busy_mask), .stage_valid(stage_valid), .bypass_hit(bypass_hit),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_eval(input logic v, input logic [NREGS-1:0] rq, input logic [NREGS-1:0] pv,
                              input logic fl, output logic e_stall, output logic e_acc,
                              output logic [NREGS-1:0] e_busy, output logic [DEPTH-1:0] e_sv,
                              output logic [NREGS-1:0] e_byp);
        logic raw, waw;
        raw = 0; waw = 0; e_busy = '0; e_sv = '0; e_byp = '0;
        for (int k = 0; k < m_prov.size(); k++) begin
            e_busy |= m_prov[k];
            e_sv[m_age[k]] = 1'b1;
            if ((rq & m_prov[k]) != 0 && !(BYP && m_age[k] == DEPTH - 1)) raw = 1;
            if ((pv & m_prov[k]) != 0) waw = 1;
            if (BYP && v && m_age[k] == DEPTH - 1) e_byp = rq & m_prov[k];
        end
        e_stall = v && (raw || waw);
        e_acc   = v && !e_stall && !fl;
    endtask

    task automatic model_reset();
        m_prov.delete();
        m_age.delete();
        m_cnt = 0;
    endtask

    task automatic cycle(input logic v, input logic [NREGS-1:0] rq, input logic [NREGS-1:0] pv,
                         input logic fl, input logic clr);
        logic e_stall, e_acc;
        logic [NREGS-1:0] e_busy, e_byp;
        logic [DEPTH-1:0] e_sv;
        id_valid = v; id_req = rq; id_prov = pv; flush = fl; stat_clr = clr;
        model_eval(v, rq, pv, fl, e_stall, e_acc, e_busy, e_sv, e_byp);
        @(negedge clk);
        s_stall = stall; s_accept = accept; s_byp = bypass_hit; s_cnt = stall_cnt;
        check("stall",       32'(stall),       32'(e_stall));
        check("accept",      32'(accept),      32'(e_acc));
        check("busy_mask",   32'(busy_mask),   32'(e_busy));
        check("stage_valid", 32'(stage_valid), 32'(e_sv));
        check("bypass_hit",  32'(bypass_hit),  32'(e_byp));
        check("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
        @(posedge clk);
        if (fl) begin
            m_prov.delete();
            m_age.delete();
        end else begin
            for (int k = m_age.size() - 1; k >= 0; k--) begin
                m_age[k]++;
                if (m_age[k] >= DEPTH) begin
                    m_age.delete(k);
                    m_prov.delete(k);
                end
            end
            if (e_acc) begin
                m_prov.push_back(pv);
                m_age.push_back(0);
            end
        end
        if (clr) m_cnt = 0;
        else if (e_stall && !fl && m_cnt < CMAX) m_cnt++;
        #1;
    endtask

    task automatic drain(input logic clr);
        repeat (DEPTH + 1) cycle(1'b0, '0, '0, 1'b0, clr);
    endtask

    initial begin
        int n_stall;
        logic [NREGS-1:0] r_req, r_prov;
        logic r_v, r_fl, r_clr;

        #1 reset = 1'b1;
        id_valid = 1'b1;
        #1;
        check("rst_stall",       32'(stall),       0);
        check("rst_accept",      32'(accept),      1);
        check("rst_busy",        32'(busy_mask),   0);
        check("rst_stage_valid", 32'(stage_valid), 0);
        check("rst_stall_cnt",   32'(stall_cnt),   0);
        id_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // independent instructions
        cycle(1, 16'h0000, 16'h0001, 0, 0);
        cycle(1, 16'h0002, 16'h0000, 0, 0);
        check("indep_stall",  32'(s_stall),  0);
        check("indep_accept", 32'(s_accept), 1);
        drain(1);

        // RAW: held until the producer retires (or reaches the bypass stage)
        cycle(1, 16'h0000, 16'h0004, 0, 0);
        n_stall = 0;
        cycle(1, 16'h0004, 16'h0000, 0, 0);
        while (s_stall && n_stall < 10) begin
            n_stall++;
            cycle(1, 16'h0004, 16'h0000, 0, 0);
        end
        check("raw_stall_cycles", 32'(n_stall),  BYP ? DEPTH - 1 : DEPTH);
        check("raw_accept",       32'(s_accept), 1);
        check("raw_stall_cnt",    32'(s_cnt),    BYP ? DEPTH - 1 : DEPTH);
        check("raw_bypass",       32'(s_byp),    BYP ? 32'h4 : 32'h0);
        drain(0);

        // async reset mid-cycle with two entries in flight and a nonzero counter
        cycle(1, 16'h0000, 16'h0001, 0, 0);
        cycle(1, 16'h0000, 16'h0002, 0, 0);
        check("pre_rst_stage_valid", 32'(stage_valid), 32'b011);
        #2 reset = 1'b1;
        #1;
        check("arst_stage_valid", 32'(stage_valid), 0);
        check("arst_busy",        32'(busy_mask),   0);
        check("arst_stall_cnt",   32'(stall_cnt),   0);
        reset = 1'b0;
        model_reset();

        // WAW
        cycle(1, 16'h0000, 16'h0010, 0, 0);
        n_stall = 0;
        cycle(1, 16'h0000, 16'h0010, 0, 0);
        while (s_stall && n_stall < 10) begin
            n_stall++;
            cycle(1, 16'h0000, 16'h0010, 0, 0);
        end
        check("waw_stall_cycles", 32'(n_stall), DEPTH);
        drain(1);

        // flush
        cycle(1, 16'h0000, 16'h00FF, 0, 0);
        cycle(1, 16'h0001, 16'h0000, 1, 0);
        check("flush_accept", 32'(s_accept), 0);
        check("flush_stall",  32'(s_stall),  1);
        check("flush_busy",   32'(busy_mask),   0);
        check("flush_stage",  32'(stage_valid), 0);
        cycle(1, 16'h0001, 16'h0000, 0, 0);
        check("post_flush_stall",  32'(s_stall),  0);
        check("post_flush_accept", 32'(s_accept), 1);
        drain(1);

        // counter saturation, then clear while stalled
        cycle(1, 16'h0000, 16'h0001, 0, 0);
        repeat (24) cycle(1, 16'h0000, 16'h0001, 0, 0);
        cycle(1, 16'h0000, 16'h0001, 0, 1);
        check("sat_stall",     32'(s_stall), 1);
        check("sat_value",     32'(s_cnt),   CMAX);
        check("clr_stall_cnt", 32'(stall_cnt), 0);
        drain(1);

        // randomized traffic; decode holds while stalled
        r_v = 0; r_req = '0; r_prov = '0;
        s_stall = 0;
        for (int n = 0; n < 500; n++) begin
            if (!s_stall) begin
                r_v    = ($urandom_range(0, 3) != 0);
                r_req  = NREGS'($urandom & $urandom);
                r_prov = ($urandom_range(0, 3) != 0) ? NREGS'(1 << $urandom_range(0, NREGS - 1)) : '0;
            end
            r_fl  = ($urandom_range(0, 15) == 0);
            r_clr = ($urandom_range(0, 19) == 0);
            cycle(r_v, r_req, r_prov, r_fl, r_clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 16-register, 3-stage NOP-injection control logic.
- Tracks register requirement/provision masks of in-flight instructions across DEPTH post-decode stages.
- Back-pressures decode with a stall (hold), not by dropping the instruction. Supports pipeline flush, an in-flight busy mask and a saturating stall-cycle counter.
- Sits between the decoder and operand fetch; decode presents one instruction's masks per cycle.

Parameters:
- NREGS, 16: architectural registers; width of every mask.
- DEPTH, 3: tracked stages after decode (OF..WB); minimum 1.
- STALL_CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- id_valid  in  1  decode presents an instruction this cycle
- id_req  in  NREGS  registers read by the decode instruction
- id_prov  in  NREGS  registers written by the decode instruction
- flush  in  1  discard all in-flight entries; blocks acceptance this cycle
- stat_clr  in  1  synchronous clear of stall_cnt
- stall  out  1  decode must hold its instruction (combinational)
- accept  out  1  id_valid & !stall & !flush (combinational)
- busy_mask  out  NREGS  OR of prov over all valid stages
- stage_valid  out  DEPTH  per-stage occupancy; bit 0 = youngest
- bypass_hit  out  NREGS  RAW satisfied by bypass from the last stage (see feature)
- stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- State: per stage i in 0..DEPTH-1, valid_i, req_i[NREGS], prov_i[NREGS].
- Reset (async, immediate on assertion): all valid/req/prov = 0, stall_cnt = 0. Therefore stall = 0, accept = id_valid, busy_mask = 0, stage_valid = 0, bypass_hit = 0.
- RAW hazard: id_req & prov_i != 0 for any valid stage i in the checked set. Without the feature, the checked set is all stages.
- WAW hazard: id_prov & prov_i != 0 for any valid stage i; always checked against all stages.
- stall = id_valid & (RAW | WAW). It is purely combinational from inputs and current state. flush does not mask stall.
- Each posedge:
  - If flush: all stages are cleared (valid = 0, masks = 0).
  - Otherwise: stage0 <= accept ? {1, id_req, id_prov} : bubble (all zeros). Stage i <= stage i-1. The last stage retires: its contents are discarded.
- Latency: an accepted entry occupies stages 0..DEPTH-1 on the DEPTH cycles after acceptance. A dependent instruction stalls at most DEPTH cycles.
- A held instruction keeps stall asserted until the blocking entry retires. Decode must keep id_* stable while stall = 1; this is not checked.
- id_valid = 0: stall = 0, accept = 0, and a bubble is inserted.
- An instruction whose own req and prov overlap does not self-hazard.
- stall_cnt, each posedge:
  - stat_clr has priority: stall_cnt <= 0.
  - Else if stall & !flush: increment, saturating at all-ones. No wrap.
- reset asserted mid-stall clears everything asynchronously. After release, the first edge sees empty state.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_BYPASS_EN.
- Defined:
  - The RAW check excludes stage DEPTH-1, because the WB result is forwarded.
  - bypass_hit = id_valid ? id_req & prov_{DEPTH-1} (when valid_{DEPTH-1}) : 0.
  - WAW still checks all stages.
  - With DEPTH = 1, RAW never stalls.
- Undefined: RAW checks all stages; bypass_hit is tied to 0.

Test Plan (NREGS=16, DEPTH=3):
- Independent: cycle0 prov=0x0001 accepted; cycle1 req=0x0002 -> stall=0, accept=1, busy_mask=0x0001.
- RAW: cycle0 prov=0x0004; cycle1 req=0x0004 held.
  - Without feature: stall=1 in cycles 1-3, accept in cycle 4, stall_cnt=3.
  - With feature: stall in cycles 1-2, cycle 3 bypass_hit=0x0004 and accept=1, stall_cnt=2.
- WAW: cycle0 prov=0x0010; cycle1 prov=0x0010 -> stall cycles 1-3 in both builds.
- Flush: cycle0 prov=0x00FF accepted; cycle1 flush=1, req=0x0001 -> accept=0, stall=1.
  - After the edge: busy_mask=0, stage_valid=0.
  - Cycle 2, same req: stall=0, accept=1.
- Async reset: assert reset between edges while stage_valid=0b011 -> stage_valid, busy_mask and stall_cnt are 0 before the next edge.
- Counter saturation: STALL_CNT_W=4, hold a hazard 20 cycles -> stall_cnt=15. Then stat_clr=1 with stall still active -> 0 after the edge.
